// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Shift-add unsigned multiplier feeding the accumulator. Two WIDTH-bit
//   operands are sampled on start and multiplied over exactly WIDTH clock
//   edges. The product is presented on productOut for a single cycle (done=1).
//   productOut is zero in every other cycle, so a downstream accumulator that
//   adds on every clock sees each product exactly once.
//
//   Handshake: start is accepted on a rising edge only while ready=1
//   (state IDLE or DONE). A start seen while busy=1 is ignored, and opA/opB
//   may change freely once the operands have been sampled.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous, active-high reset
//   start       begin a multiply (sampled with opA/opB when ready=1)
//   opA, opB    unsigned multiplicand / multiplier, WIDTH bits
//   ready       start will be accepted on the next edge (IDLE or DONE)
//   busy        multiply in progress (RUN)
//   done        one-cycle pulse, productOut holds the product
//   productOut  product when done=1, otherwise 0 (zero-extended to 32 bits)
//   dbg_state   current FSM state, for debug and assertion binding
module seq_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  opA,
   input  logic [WIDTH-1:0]  opB,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [31:0]       productOut,
   output logic [1:0]        dbg_state
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [PW-1:0]    mcand;
   logic [PW-1:0]    partial;
   logic [WIDTH-1:0] mplier;
   logic [PW-1:0]    partial_next;

   // Partial sum including the bit processed on this edge; on the final
   // edge this is the complete product and goes straight to productOut.
   assign partial_next = mplier[0] ? (partial + mcand) : partial;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         count      <= '0;
         mcand      <= '0;
         mplier     <= '0;
         partial    <= '0;
         productOut <= '0;
      end else begin
         case (state)
            // IDLE and DONE both accept a new request; leaving DONE always
            // clears productOut so the product is seen for one cycle only.
            S_IDLE, S_DONE: begin
               productOut <= '0;
               if (start) begin
                  mcand   <= PW'(opA);
                  mplier  <= opB;
                  partial <= '0;
                  count   <= '0;
                  state   <= S_RUN;
               end else begin
                  state   <= S_IDLE;
               end
            end
            S_RUN: begin
               partial <= partial_next;
               mcand   <= mcand << 1;
               mplier  <= mplier >> 1;
               count   <= count + CW'(1);
               if (count == LAST) begin
                  state      <= S_DONE;
                  productOut <= 32'(partial_next);
               end
            end
            default: begin
               state      <= S_IDLE;
               productOut <= '0;
            end
         endcase
      end
   end

   // Status is decoded from the state register only, never from inputs.
   assign busy      = (state == S_RUN);
   assign ready     = ~busy;
   assign done      = (state == S_DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [W-1:0]  opA = '0, opB = '0;
  logic          ready, busy, done;
  logic [31:0]   productOut;
  logic [1:0]    dbg_state;

  seq_multiplier #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .opA(opA), .opB(opB),
    .ready(ready), .busy(busy), .done(done), .productOut(productOut),
    .dbg_state(dbg_state)
  );

  // Narrow instance for the WIDTH=4 latency/product case.
  logic          start4 = 1'b0;
  logic [3:0]    opA4 = '0, opB4 = '0;
  logic          ready4, busy4, done4;
  logic [31:0]   productOut4;
  logic [1:0]    dbg_state4;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .opA(opA4), .opB(opB4),
    .ready(ready4), .busy(busy4), .done(done4), .productOut(productOut4),
    .dbg_state(dbg_state4)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A request accepted on edge e is busy after edges e..e+W-1, presents its
  // product after edge e+W, and a new request is accepted on any edge where
  // the model was not busy after the previous edge.
  logic [31:0] exp_q[$];
  int  cyc = 0;
  int  acc_edge = 0;
  bit  have = 1'b0;

  function automatic bit model_busy(input int k);
    return have && (acc_edge <= k) && (k < acc_edge + W);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      have = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      if (start && !model_busy(cyc - 1)) begin
        have     = 1'b1;
        acc_edge = cyc;
        exp_q.push_back(32'(opA) * 32'(opB));
      end
    end
  end

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    logic        e_busy, e_done;
    logic [31:0] e_prod;
    e_busy = model_busy(cyc);
    e_done = have && (cyc == acc_edge + W);
    e_prod = 32'h0;
    if (e_done) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL scoreboard: done expected but queue empty at %0t", $time);
      end else begin
        e_prod = exp_q.pop_front();
      end
    end
    check("busy", 32'(busy), 32'(e_busy));
    check("ready", 32'(ready), 32'(!e_busy));
    check("done", 32'(done), 32'(e_done));
    check("productOut", productOut, e_prod);
  end

  // Accumulator that adds productOut on every clock.
  logic [31:0] ac_sum;
  always @(posedge clk or posedge rst) begin
    if (rst) ac_sum <= '0;
    else     ac_sum <= ac_sum + productOut;
  end

  // ---------------- driver tasks ----------------
  // Counts negedges from the one before E0; done is expected on count W+1.
  task automatic run_until_done(input bit drop_start, output int n, output logic [31:0] p);
    n = 0;
    p = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (drop_start && n == 1) start = 1'b0;
      if (done) begin
        p = productOut;
        return;
      end
    end
    check("done_timeout", 32'd0, 32'd1);
    n = -1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    opA = a;
    opB = b;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n, m, cnt;
    logic [31:0] p;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_prod", productOut, 32'd0);
    rst = 1'b0;

    // 1: 3 x 5
    launch(16'd3, 16'd5);
    run_until_done(1'b1, n, p);
    check("t1_latency", 32'(n), 32'(W + 1));
    check("t1_prod", p, 32'h0000000F);

    // 2: extremes
    launch(16'hFFFF, 16'hFFFF);
    run_until_done(1'b1, n, p);
    check("t2_latency_max", 32'(n), 32'(W + 1));
    check("t2_prod_max", p, 32'hFFFE0001);
    launch(16'h0000, 16'h1234);
    run_until_done(1'b1, n, p);
    check("t2_latency_zero", 32'(n), 32'(W + 1));
    check("t2_prod_zero", p, 32'h0);

    // 3: start during RUN is ignored
    launch(16'd7, 16'd9);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; opA = 16'd2; opB = 16'd2;
    @(negedge clk);
    check("t3_ready_in_run", 32'(ready), 32'd0);
    start = 1'b0;
    run_until_done(1'b0, n, p);
    check("t3_latency", 32'(n), 32'(W + 1 - 6));
    check("t3_prod", p, 32'd63);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("t3_single_done", 32'(cnt), 32'd0);

    // 4: back-to-back with start held high
    launch(16'd7, 16'd9);
    run_until_done(1'b0, n, p);
    check("t4_first", p, 32'd63);
    opA = 16'd10; opB = 16'd10;
    run_until_done(1'b1, m, p);
    check("t4_gap", 32'(m), 32'(W + 1));
    check("t4_second", p, 32'd100);

    // 5: async reset mid-multiply
    launch(16'd5, 16'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(ready), 32'd1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_prod", productOut, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("t5_no_done", 32'(cnt), 32'd0);
    launch(16'd4, 16'd4);
    run_until_done(1'b1, n, p);
    check("t5_after", p, 32'd16);

    // 6: accumulator integration
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    launch(16'd3, 16'd5);
    run_until_done(1'b1, n, p);
    @(negedge clk);
    check("t6_ac_first", ac_sum, 32'd15);
    repeat (5) @(negedge clk);
    check("t6_ac_hold", ac_sum, 32'd15);
    launch(16'd6, 16'd7);
    run_until_done(1'b1, n, p);
    @(negedge clk);
    check("t6_ac_second", ac_sum, 32'd57);

    // WIDTH=4: 15 x 15
    @(negedge clk);
    start4 = 1'b1; opA4 = 4'd15; opB4 = 4'd15;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start4 = 1'b0;
        check("w4_busy", 32'(busy4), 32'd1);
      end
      if (done4) break;
    end
    check("w4_latency", 32'(n), 32'd5);
    check("w4_prod", productOut4, 32'd225);

    // Random: overlapping/held starts, operand churn during RUN.
    for (int it = 0; it < 30; it++) begin
      launch(rnd_op(), rnd_op());
      repeat ($urandom_range(1, 40)) begin
        @(negedge clk);
        opA = rnd_op();
        opB = rnd_op();
      end
      start = 1'b0;
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (W + 4) @(negedge clk);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
